// File: rtl/com_ecc_pkg.sv
// rtl/com_ecc_pkg.sv - shared types and helpers for the ECC scrub controller
// Purpose: scrub FSM state enum, ECC error bit indices, saturating increment.
// Ports: none (package).
package com_ecc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RD,
    ST_LAT,
    ST_WB,
    ST_NEXT
  } scrub_state_e;

  localparam int ERR_CE = 0;
  localparam int ERR_UE = 1;

  // Saturating increment for counters of up to 32 bits; holds at all ones.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [32:0] lim;
    lim = (33'd1 << width) - 33'd1;
    return (val == lim[31:0]) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/com_sat_cnt.sv
// rtl/com_sat_cnt.sv - saturating event counter
// Purpose: counts single-cycle inc requests, sticks at all ones.
// Ports: clk, rst_n (async active-low), inc (count enable), cnt (current value).
module com_sat_cnt
  import com_ecc_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= W'(sat_inc(32'(cnt), W));
    end
  end

endmodule

// File: rtl/com_ecc_scrub_ctrl.sv
// rtl/com_ecc_scrub_ctrl.sv - background ECC scrubber in front of an ECC SP-RAM shell
// Purpose: walks all RAM addresses in user-idle cycles, writes back corrected
//   data on correctable errors, counts CE/UE events. User port has priority.
// Ports: clk, rst_n; cfg_scrub_en/cfg_interval (config); usr_* (functional
//   port, passed through when usr_ce_n=0); ram_* (to/from shell);
//   o_ce_cnt/o_ue_cnt (saturating counts), o_ue_addr (first UE address),
//   o_pls_pass_done (pulse per completed pass).
// Optional: COM_ECC_SCRUB_UE_LOG_EN enables the first-UE address capture;
//   without it o_ue_addr is tied to 0.
module com_ecc_scrub_ctrl
  import com_ecc_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 64,
  parameter  int STRB_W = 1,
  parameter  int RD_LAT = 1,
  parameter  int INTV_W = 16,
  parameter  int CNT_W  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_scrub_en,
  input  logic [INTV_W-1:0] cfg_interval,
  input  logic              usr_ce_n,
  input  logic [STRB_W-1:0] usr_we,
  input  logic [ADDR_W-1:0] usr_addr,
  input  logic [DATA_W-1:0] usr_wr_data,
  output logic [DATA_W-1:0] usr_rd_data,
  output logic              ram_ce_n,
  output logic [STRB_W-1:0] ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  input  logic [DATA_W-1:0] ram_rd_data,
  input  logic [1:0]        ram_ecc_err,
  output logic [CNT_W-1:0]  o_ce_cnt,
  output logic [CNT_W-1:0]  o_ue_cnt,
  output logic [ADDR_W-1:0] o_ue_addr,
  output logic              o_pls_pass_done
);

  scrub_state_e      state_q, state_d;
  logic [ADDR_W-1:0] scrub_addr_q;
  logic [INTV_W-1:0] intv_q;
  logic [2:0]        lat_q;
  logic [DATA_W-1:0] data_q;
  logic              hazard_q;
  logic              pass_q;

  logic              scr_ce_n;
  logic [STRB_W-1:0] scr_we;
  logic              ce_inc, ue_inc, capture;
  logic              usr_wr_hit, lat_done, addr_last;

  // A user write to the item being scrubbed makes the latched data stale.
  assign usr_wr_hit = !usr_ce_n && (|usr_we) && (usr_addr == scrub_addr_q);
  assign lat_done   = (lat_q == 3'd0);
  assign addr_last  = (scrub_addr_q == ADDR_W'(DEPTH - 1));

  always_comb begin
    state_d  = state_q;
    scr_ce_n = 1'b1;
    scr_we   = '0;
    ce_inc   = 1'b0;
    ue_inc   = 1'b0;
    capture  = 1'b0;
    case (state_q)
      ST_IDLE: if (cfg_scrub_en) state_d = ST_WAIT;
      ST_WAIT: begin
        if (!cfg_scrub_en) state_d = ST_IDLE;
        else if (intv_q <= INTV_W'(1)) state_d = ST_RD;
      end
      ST_RD: begin
        if (usr_ce_n) begin
          scr_ce_n = 1'b0;
          state_d  = ST_LAT;
        end
      end
      ST_LAT: begin
        if (lat_done) begin
          state_d = ST_NEXT;
          if (ram_ecc_err[ERR_UE]) begin
            ue_inc = 1'b1;
          end else if (ram_ecc_err[ERR_CE]) begin
            if (hazard_q || usr_wr_hit) ce_inc = 1'b1;
            else begin
              capture = 1'b1;
              state_d = ST_WB;
            end
          end
        end
      end
      ST_WB: begin
        if (usr_wr_hit) begin
          ce_inc  = 1'b1;
          state_d = ST_NEXT;
        end else if (usr_ce_n) begin
          scr_ce_n = 1'b0;
          scr_we   = '1;
          ce_inc   = 1'b1;
          state_d  = ST_NEXT;
        end
      end
      ST_NEXT: state_d = cfg_scrub_en ? ST_WAIT : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      scrub_addr_q <= '0;
      intv_q       <= '0;
      lat_q        <= '0;
      data_q       <= '0;
      hazard_q     <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      pass_q  <= (state_q == ST_NEXT) && addr_last;
      if (capture) data_q <= ram_rd_data;
      case (state_q)
        ST_IDLE: intv_q <= cfg_interval;
        ST_WAIT: if (intv_q != '0) intv_q <= intv_q - INTV_W'(1);
        ST_RD: begin
          lat_q    <= 3'(RD_LAT - 1);
          hazard_q <= 1'b0;
        end
        ST_LAT: begin
          if (usr_wr_hit) hazard_q <= 1'b1;
          if (!lat_done) lat_q <= lat_q - 3'd1;
        end
        ST_NEXT: begin
          intv_q       <= cfg_interval;
          scrub_addr_q <= addr_last ? '0 : scrub_addr_q + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  com_sat_cnt #(.W(CNT_W)) u_ce_cnt (.clk(clk), .rst_n(rst_n), .inc(ce_inc), .cnt(o_ce_cnt));
  com_sat_cnt #(.W(CNT_W)) u_ue_cnt (.clk(clk), .rst_n(rst_n), .inc(ue_inc), .cnt(o_ue_cnt));

`ifdef COM_ECC_SCRUB_UE_LOG_EN
  logic [ADDR_W-1:0] ue_addr_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ue_addr_q <= '0;
    else if (ue_inc && (o_ue_cnt == '0)) ue_addr_q <= scrub_addr_q;
  end
  assign o_ue_addr = ue_addr_q;
`else
  assign o_ue_addr = '0;
`endif

  assign o_pls_pass_done = pass_q;

  // User port wins combinationally; scrub request only when the user is idle.
  assign ram_ce_n    = usr_ce_n ? scr_ce_n : 1'b0;
  assign ram_we      = usr_ce_n ? scr_we : usr_we;
  assign ram_addr    = usr_ce_n ? scrub_addr_q : usr_addr;
  assign ram_wr_data = usr_ce_n ? data_q : usr_wr_data;
  assign usr_rd_data = ram_rd_data;

endmodule

// File: tb/tb_com_ecc_scrub_ctrl.sv
// tb/tb_com_ecc_scrub_ctrl.sv - self-checking bench for com_ecc_scrub_ctrl
module tb_com_ecc_scrub_ctrl;
  localparam int DATA_W = 32, DEPTH = 8, STRB_W = 1, RD_LAT = 1;
  localparam int INTV_W = 16, CNT_W = 2, ADDR_W = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0, cfg_scrub_en = 1'b0, usr_ce_n = 1'b1;
  logic [INTV_W-1:0] cfg_interval = '0;
  logic [STRB_W-1:0] usr_we = '0, ram_we;
  logic [ADDR_W-1:0] usr_addr = '0, ram_addr, o_ue_addr;
  logic [DATA_W-1:0] usr_wr_data = '0, usr_rd_data, ram_wr_data;
  logic [DATA_W-1:0] ram_rd_data = '0;
  logic [1:0]        ram_ecc_err = '0;
  logic              ram_ce_n, o_pls_pass_done;
  logic [CNT_W-1:0]  o_ce_cnt, o_ue_cnt;

  com_ecc_scrub_ctrl #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .STRB_W(STRB_W), .RD_LAT(RD_LAT),
    .INTV_W(INTV_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_scrub_en(cfg_scrub_en), .cfg_interval(cfg_interval),
    .usr_ce_n(usr_ce_n), .usr_we(usr_we), .usr_addr(usr_addr), .usr_wr_data(usr_wr_data),
    .usr_rd_data(usr_rd_data), .ram_ce_n(ram_ce_n), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data), .ram_ecc_err(ram_ecc_err),
    .o_ce_cnt(o_ce_cnt), .o_ue_cnt(o_ue_cnt), .o_ue_addr(o_ue_addr),
    .o_pls_pass_done(o_pls_pass_done)
  );

  int checks = 0, errors = 0;

  // RAM shell model: RD_LAT=1, per-address injected error bits, a write clears them.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [1:0]        err_map [DEPTH];
  logic [DATA_W-1:0] init_mem [DEPTH];
  logic [1:0]        init_err [DEPTH];
  logic              load_req = 1'b0;

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i]     <= init_mem[i];
        err_map[i] <= init_err[i];
      end
      ram_ecc_err <= 2'b00;
    end else if (!ram_ce_n) begin
      if (ram_we[0]) begin
        mem[ram_addr]     <= ram_wr_data;
        err_map[ram_addr] <= 2'b00;
        ram_ecc_err       <= 2'b00;
      end else begin
        ram_rd_data <= mem[ram_addr];
        ram_ecc_err <= err_map[ram_addr];
      end
    end else begin
      ram_ecc_err <= 2'b00;
    end
  end

  // Log of scrubber-originated RAM accesses (user idle, RAM enabled).
  typedef struct packed {
    logic [31:0]       cyc;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } acc_t;
  acc_t log_q[$];
  acc_t mon_a;
  int unsigned cyc = 0;

  always @(posedge clk) begin
    if (rst_n && usr_ce_n && !ram_ce_n) begin
      mon_a.cyc  = cyc;
      mon_a.we   = ram_we[0];
      mon_a.addr = ram_addr;
      mon_a.data = ram_wr_data;
      log_q.push_back(mon_a);
    end
    cyc <= cyc + 1;
  end

  // Reference model for one full pass over the preloaded RAM.
  acc_t exp_q[$];
  int exp_ce, exp_ue, exp_ue_addr;

  task automatic build_model();
    acc_t e;
    int ce = 0, ue = 0, first = -1;
    exp_q.delete();
    for (int a = 0; a < DEPTH; a++) begin
      e = '0; e.addr = ADDR_W'(a);
      exp_q.push_back(e);
      if (init_err[a][1]) begin
        ue++;
        if (first < 0) first = a;
      end else if (init_err[a][0]) begin
        e.we = 1'b1; e.data = init_mem[a];
        exp_q.push_back(e);
        ce++;
      end
    end
    exp_ce = (ce > CNT_MAX) ? CNT_MAX : ce;
    exp_ue = (ue > CNT_MAX) ? CNT_MAX : ue;
`ifdef COM_ECC_SCRUB_UE_LOG_EN
    exp_ue_addr = (first < 0) ? 0 : first;
`else
    exp_ue_addr = 0;
`endif
  endtask

  // Index of first log entry (from base) disagreeing with exp_q, or -1.
  function automatic int seq_diff(int base);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i >= log_q.size()) return i;
      if (log_q[base+i].we !== exp_q[i].we || log_q[base+i].addr !== exp_q[i].addr) return i;
      if (exp_q[i].we && log_q[base+i].data !== exp_q[i].data) return i;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; cfg_scrub_en = 1'b0; usr_ce_n = 1'b1; usr_we = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic load_ram();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  task automatic fill_random(input int mode);
    int r;
    for (int i = 0; i < DEPTH; i++) begin
      init_mem[i] = $urandom;
      r = (mode != 0) ? $urandom_range(0, 5) : 0;
      init_err[i] = (r == 3) ? 2'b01 : (r == 4) ? 2'b10 : (r == 5) ? 2'b11 : 2'b00;
    end
  endtask

  task automatic run_pass(input int intv, output int base, output bit ok);
    base = log_q.size();
    ok = 1'b0;
    cfg_interval = INTV_W'(intv);
    cfg_scrub_en = 1'b1;
    for (int i = 0; i < DEPTH * (intv + 8) + 20; i++) begin
      tick();
      if (o_pls_pass_done) begin ok = 1'b1; break; end
    end
    cfg_scrub_en = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL pass_timeout: o_pls_pass_done never seen, required a pulse");
    end else begin
      tick();
      if (o_pls_pass_done !== 1'b0) begin
        errors++;
        $display("FAIL pass_pulse_width: o_pls_pass_done=%0b, required 0", o_pls_pass_done);
      end
    end
  endtask

  task automatic wait_scrub_rd(input int addr, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (usr_ce_n && !ram_ce_n && ram_we == '0 && ram_addr == ADDR_W'(addr)) begin
        ok = 1'b1; break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_rd_%0d: scrub read never issued, required one", addr);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({o_ce_cnt, o_ue_cnt, o_ue_addr, o_pls_pass_done, ram_ce_n} !== {{(2*CNT_W+ADDR_W+1){1'b0}}, 1'b1}) begin
      errors++;
      $display("FAIL reset_outputs: ce=%0d ue=%0d ue_addr=%0d pass=%0b ce_n=%0b, required 0 0 0 0 1",
               o_ce_cnt, o_ue_cnt, o_ue_addr, o_pls_pass_done, ram_ce_n);
    end
    apply_reset();
  endtask

  // Full pass with given error map; compare access sequence and counters.
  task automatic test_pass(input string name, input int intv, input bit check_spacing);
    int base, d;
    bit ok;
    apply_reset();
    load_ram();
    build_model();
    run_pass(intv, base, ok);
    d = seq_diff(base);
    checks++;
    if (d != -1 || log_q.size() - base != exp_q.size()) begin
      errors++;
      $display("FAIL %s_seq: entries=%0d first_bad=%0d, required %0d entries matching model",
               name, log_q.size() - base, d, exp_q.size());
    end
    checks++;
    if (o_ce_cnt !== CNT_W'(exp_ce) || o_ue_cnt !== CNT_W'(exp_ue)) begin
      errors++;
      $display("FAIL %s_cnt: ce=%0d ue=%0d, required ce=%0d ue=%0d", name, o_ce_cnt, o_ue_cnt, exp_ce, exp_ue);
    end
    checks++;
    if (o_ue_addr !== ADDR_W'(exp_ue_addr)) begin
      errors++;
      $display("FAIL %s_ue_addr: got %0d, required %0d", name, o_ue_addr, exp_ue_addr);
    end
    if (check_spacing && log_q.size() - base >= DEPTH) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        checks++;
        if (log_q[base+i+1].cyc - log_q[base+i].cyc !== 32'(intv + 3)) begin
          errors++;
          $display("FAIL %s_spacing_%0d: gap=%0d, required %0d", name, i,
                   log_q[base+i+1].cyc - log_q[base+i].cyc, intv + 3);
        end
      end
    end
  endtask

  task automatic test_clean_pass();
    fill_random(0);
    test_pass("clean", 2, 1'b1);
  endtask

  task automatic test_ce_writeback();
    fill_random(0);
    init_mem[3] = 32'hA5A5_A5A5;
    init_err[3] = 2'b01;
    test_pass("ce_wb", 2, 1'b0);
  endtask

  task automatic test_ue_log();
    fill_random(0);
    init_err[5] = 2'b10;
    init_err[6] = 2'b11;
    test_pass("ue_log", 1, 1'b0);
  endtask

  task automatic test_saturation();
    fill_random(0);
    init_err[0] = 2'b01; init_err[1] = 2'b01; init_err[2] = 2'b01;
    init_err[4] = 2'b01; init_err[7] = 2'b01;
    test_pass("sat", 0, 1'b0);
  endtask

  task automatic test_random_passes();
    for (int k = 0; k < 4; k++) begin
      fill_random(1);
      test_pass($sformatf("rand%0d", k), $urandom_range(0, 3), 1'b0);
    end
  endtask

  task automatic test_user_priority();
    int base, rel, n;
    bit seen;
    apply_reset();
    fill_random(0);
    load_ram();
    base = log_q.size();
    cfg_interval = INTV_W'(2);
    cfg_scrub_en = 1'b1;
    usr_ce_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      usr_we = STRB_W'($urandom_range(0, 1));
      usr_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
      usr_wr_data = $urandom;
      #1;
      checks++;
      if (ram_ce_n !== 1'b0 || ram_we !== usr_we || ram_addr !== usr_addr || ram_wr_data !== usr_wr_data) begin
        errors++;
        $display("FAIL usr_pass_%0d: ce_n=%0b we=%0b addr=%0d data=%h, required 0 %0b %0d %h",
                 i, ram_ce_n, ram_we, ram_addr, ram_wr_data, usr_we, usr_addr, usr_wr_data);
      end
      tick();
    end
    usr_ce_n = 1'b1;
    usr_we = '0;
    rel = cyc;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = (log_q.size() > base);
    end
    cfg_scrub_en = 1'b0;
    n = log_q.size() - base;
    checks++;
    if (!seen || log_q[base].cyc !== 32'(rel) || log_q[base].addr !== '0 || log_q[base].we !== 1'b0) begin
      errors++;
      $display("FAIL usr_release_issue: entries=%0d cyc=%0d addr=%0d, required read of addr 0 at cyc %0d",
               n, seen ? log_q[base].cyc : 0, seen ? log_q[base].addr : 0, rel);
    end
  endtask

  task automatic test_hazard();
    int base, d;
    bit ok, wrote;
    apply_reset();
    fill_random(0);
    init_err[2] = 2'b01;
    load_ram();
    base = log_q.size();
    cfg_interval = INTV_W'(2);
    cfg_scrub_en = 1'b1;
    wait_scrub_rd(2, ok);
    tick();
    usr_ce_n = 1'b0; usr_we = '1; usr_addr = ADDR_W'(2); usr_wr_data = $urandom;
    tick();
    usr_ce_n = 1'b1; usr_we = '0;
    for (int i = 0; i < 50 && log_q.size() < base + 4; i++) tick();
    cfg_scrub_en = 1'b0;
    wrote = 1'b0;
    for (int i = base; i < log_q.size(); i++) if (log_q[i].we) wrote = 1'b1;
    checks++;
    if (wrote) begin
      errors++;
      $display("FAIL hazard_no_wb: writeback seen=1, required 0");
    end
    d = log_q.size() - base;
    checks++;
    if (d < 4 || log_q[base+3].addr !== ADDR_W'(3) || log_q[base+3].we !== 1'b0) begin
      errors++;
      $display("FAIL hazard_next_addr: entries=%0d addr=%0d, required read of addr 3",
               d, (d >= 4) ? log_q[base+3].addr : 0);
    end
    checks++;
    if (o_ce_cnt !== CNT_W'(1)) begin
      errors++;
      $display("FAIL hazard_ce_cnt: got %0d, required 1", o_ce_cnt);
    end
  endtask

  task automatic test_reset_mid_lat();
    int base;
    bit ok;
    apply_reset();
    fill_random(0);
    init_err[1] = 2'b01;
    load_ram();
    cfg_interval = '0;
    cfg_scrub_en = 1'b1;
    wait_scrub_rd(4, ok);
    tick();
    checks++;
    if (o_ce_cnt !== CNT_W'(1)) begin
      errors++;
      $display("FAIL pre_reset_ce_cnt: got %0d, required 1", o_ce_cnt);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_ce_cnt !== '0 || o_ue_cnt !== '0 || o_ue_addr !== '0 || o_pls_pass_done !== 1'b0 || ram_ce_n !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: ce=%0d ue=%0d ue_addr=%0d pass=%0b ce_n=%0b, required 0 0 0 0 1",
               o_ce_cnt, o_ue_cnt, o_ue_addr, o_pls_pass_done, ram_ce_n);
    end
    cfg_scrub_en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    base = log_q.size();
    cfg_scrub_en = 1'b1;
    for (int i = 0; i < 20 && log_q.size() == base; i++) tick();
    cfg_scrub_en = 1'b0;
    checks++;
    if (log_q.size() == base || log_q[base].addr !== '0) begin
      errors++;
      $display("FAIL restart_addr: got %0d, required 0", (log_q.size() > base) ? log_q[base].addr : 7);
    end
  endtask

  initial begin
    test_reset();
    test_clean_pass();
    test_ce_writeback();
    test_ue_log();
    test_saturation();
    test_random_passes();
    test_user_priority();
    test_hazard();
    test_reset_mid_lat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
